// File: rtl/mux_pkg.sv
// Shared types and sizes for the mux scan controller.
// Holds the FSM state enum, mux width and select width.
package mux_pkg;

  localparam int MUX_WIDTH = 16;
  localparam int SEL_W     = 4;
  localparam int WCNT_W    = 4;

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(MUX_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

endpackage

// File: rtl/mux_scan_ctrl_settle_timer.sv
// settle_timer: loadable down-counter with a zero flag.
// Ports: clk, rst_n (sync, active-low), load, load_val, dec, zero.
module settle_timer
  import mux_pkg::*;
#(
  parameter int W = WCNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: walks sel 0..15 over a 16:1 mux, settles, samples bit_in
// into a 16-bit word and hands it out with a valid/ready handshake.
// Ports: clk, rst_n (sync, active-low), start, sel[3:0], bit_in,
//   data[15:0], data_valid, data_ready, busy.
// Param SETTLE_CYCLES (0..15): wait cycles after each sel change.
// Macro MUX_SCAN_CONT_EN: continuous mode, rescan after each handshake.
module mux_scan_ctrl
  import mux_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [SEL_W-1:0]     sel,
  input  logic                 bit_in,
  output logic [MUX_WIDTH-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 busy
);

  localparam logic [WCNT_W-1:0] SETTLE = WCNT_W'(SETTLE_CYCLES);

  state_t               state;
  logic [MUX_WIDTH-1:0] shadow;
  logic                 t_load;
  logic                 t_dec;
  logic                 t_zero;
  logic                 accept;

  assign accept = data_valid && data_ready;

  // Timer control: reload on every new sel, count down while settling.
  always_comb begin
    t_load = 1'b0;
    t_dec  = 1'b0;
    unique case (state)
      IDLE: t_load = start;
      SCAN: begin
        if (!t_zero) begin
          t_dec = 1'b1;
        end else if (sel != SEL_LAST) begin
          t_load = 1'b1;
        end
      end
      DONE: begin
`ifdef MUX_SCAN_CONT_EN
        t_load = accept;
`endif
      end
      default: ;
    endcase
  end

  settle_timer #(
    .W(WCNT_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (t_load),
    .load_val(SETTLE),
    .dec     (t_dec),
    .zero    (t_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel        <= '0;
      shadow     <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= SCAN;
            sel   <= '0;
            busy  <= 1'b1;
          end
        end
        SCAN: begin
          if (t_zero) begin
            shadow[sel] <= bit_in;
            if (sel == SEL_LAST) begin
              // bit 15 goes straight into data with the shadowed bits
              data       <= {bit_in, shadow[MUX_WIDTH-2:0]};
              data_valid <= 1'b1;
              state      <= DONE;
            end else begin
              sel <= sel + 1'b1;
            end
          end
        end
        DONE: begin
          if (accept) begin
            data_valid <= 1'b0;
            sel        <= '0;
`ifdef MUX_SCAN_CONT_EN
            state      <= SCAN;
`else
            state      <= IDLE;
            busy       <= 1'b0;
`endif
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
